people_counter: RTL

Front-end stage of the smart bank queue manager. It conditions the two photocell inputs (queue entrance and teller exit) and maintains the number of customers currently in the queue as `Pcount`. This count drives the downstream queue status and wait-time logic. The block synchronises and debounces each sensor, converts each complete beam interruption into a single event, and saturates the count at 0 and 2^N−1.

---
 rtl/people_counter_pkg.sv | 6 +
 rtl/people_counter_photocell_filter.sv | 41 ++++
 rtl/people_counter.sv | 36 +++
 3 files changed

// File: rtl/people_counter_pkg.sv
// people_counter_pkg: shared SBqM constants and photocell filter state type
package people_counter_pkg;
  localparam int N_DEFAULT = 3;
  localparam int DEB_DEFAULT = 4;
  typedef enum logic [1:0] {IDLE, QUAL_BLK, BLOCKED, QUAL_REL} filt_state_t;
endpackage

// File: rtl/people_counter_photocell_filter.sv
// photocell_filter: synchronise and debounce one photocell, strobe on confirmed release
module photocell_filter
  import people_counter_pkg::*;
#(
  parameter int DEB = DEB_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor,
  output logic fall
);
  localparam int CW = DEB > 1 ? $clog2(DEB) : 1;
  logic s1, s2, filt, differ, accept;
  logic [CW-1:0] cnt;
  filt_state_t state;
  assign filt = (state == BLOCKED) || (state == QUAL_REL);
  assign differ = s2 != filt;
  assign accept = differ && (cnt == CW'(DEB - 1));
  // two-flop synchroniser for the asynchronous photocell level
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sensor;
      s2 <= s1;
    end
  // count differing cycles, flip the accepted level after DEB of them, flag 1->0 flips
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      fall  <= 1'b0;
    end else begin
      cnt   <= (differ && !accept) ? cnt + 1'b1 : '0;
      state <= accept ? (filt ? IDLE : BLOCKED) :
               differ ? (filt ? QUAL_REL : QUAL_BLK) :
               (filt ? BLOCKED : IDLE);
      fall  <= accept && filt;
    end
endmodule

// File: rtl/people_counter.sv
// people_counter: debounced entrance/exit photocells driving a saturating queue count
module people_counter
  import people_counter_pkg::*;
#(
  parameter int N   = N_DEFAULT,
  parameter int DEB = DEB_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         front_sensor,
  input  logic         back_sensor,
  output logic [N-1:0] Pcount,
  output logic         entry_pulse,
  output logic         exit_pulse,
  output logic         reject
);
  logic e, x, full, empty;
  photocell_filter #(.DEB(DEB)) u_front (.clk(clk), .reset(reset), .sensor(front_sensor), .fall(e));
  photocell_filter #(.DEB(DEB)) u_back (.clk(clk), .reset(reset), .sensor(back_sensor), .fall(x));
  assign full = &Pcount;
  assign empty = Pcount == '0;
  // saturating count; simultaneous entry and exit cancel and both strobe
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      Pcount      <= '0;
      entry_pulse <= 1'b0;
      exit_pulse  <= 1'b0;
      reject      <= 1'b0;
    end else begin
      Pcount      <= (e && !x && !full) ? Pcount + 1'b1 :
                     (x && !e && !empty) ? Pcount - 1'b1 : Pcount;
      entry_pulse <= e && (x || !full);
      exit_pulse  <= x && (e || !empty);
      reject      <= (e && !x && full) || (x && !e && empty);
    end
endmodule
